clock_display_driver: RTL and testbench
=======================================

CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter REFRESH_HZ, default 1000, digit-slot rate in Hz; DIG_CYC = CLK_HZ/REFRESH_HZ cycles per slot.
REQ-003 SHALL have parameter BLANK_CYC, default 16, anti-ghost blank cycles at the start of each slot; must be < DIG_CYC.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports h2 h1 m2 m1 s2 s1, input, 4 each, BCD time digits (tens, units).
REQ-007 SHALL have port mode_sel, input, 1: 0 = HH.MM, 1 = MM.SS.
REQ-008 SHALL have port an, output, 4, active-low anodes; an[0] is the rightmost digit.
REQ-009 SHALL have port seg, output, 7, active-low cathodes; seg[0]=a through seg[6]=g.
REQ-010 SHALL have port dp, output, 1, active-low decimal point.

Function
REQ-011 SHALL run a slot counter 0..DIG_CYC-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-012 SHALL, when the index enters 0 and on the first cycle after reset, snapshot four digits and mode_sel: mode 0 gives {h2,h1,m2,m1}, mode 1 gives {m2,m1,s2,s1} (index 3..0); input changes mid-frame SHALL NOT affect the current frame.
REQ-013 SHALL drive an = all ones while the slot counter < BLANK_CYC; otherwise only an[index] low.
REQ-014 SHALL decode snapshot digits 0-9 to standard 7-segment patterns; values 10-15 SHALL show '-' (only g lit, seg = 7'b0111111).
REQ-015 SHALL run a half-second counter of CLK_HZ/2 cycles that toggles blink phase, giving 1 Hz at 50% duty; phase = 1 (lit) after reset.
REQ-016 SHALL drive dp = 0 only when index = 2, the slot is unblanked and phase = 1; dp = 1 otherwise.
REQ-017 SHALL register an, seg and dp: each reflects the counter and index state with exactly one clock of latency.
REQ-018 SHALL run both counters freely and independently; simultaneous terminal counts SHALL both take effect in the same cycle.

Reset
REQ-019 SHALL, on rst, set an = 4'b1111, seg = 7'b1111111, dp = 1, index = 0, both counters = 0, snapshot = 0 and phase = 1.
REQ-020 SHALL, if rst is asserted mid-slot or mid-frame, apply the reset state on the next edge; the scan restarts at index 0 with a fresh snapshot once rst is released.

Configuration
REQ-021 SHALL, with LEADING_ZERO_BLANK_EN defined, hold an[3] high for the whole index-3 slot when the snapshot index-3 digit is 0.
REQ-022 SHALL, without LEADING_ZERO_BLANK_EN, display a 0 in the index-3 digit as '0'.

Structure
REQ-023 SHALL place the segment pattern constants (digits 0-9, dash, blank) and the 2-bit digit-index typedef in package clock_disp_pkg.
REQ-024 SHALL implement the decode in one combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out).

Verification (CLK_HZ=1000, REFRESH_HZ=100 -> DIG_CYC=10, BLANK_CYC=2, half-second = 500 cycles)
REQ-025 SHALL test the scan: mode 0 with h=12, m=34. Expected: an cycles 1110, 1101, 1011, 0111 per 10-cycle slot, blank for 2 cycles each; seg shows 4, 3, 2, 1.
REQ-026 SHALL test mid-frame input changes: change m1 from 4 to 7 during index 2. Expected: '4' persists until the next frame; '7' appears at the next index-0 slot.
REQ-027 SHALL test the decimal point: over 1000 cycles, dp is low during the unblanked index-2 slots of the first 500 cycles only, then high for the next 500.
REQ-028 SHALL test invalid BCD and mode change: s1 = 4'hC in mode 1. Expected: the index-0 slot shows seg = 7'b0111111.
REQ-029 SHALL test leading-zero blanking: with h2 = 0, an[3] never goes low with the macro defined; without the macro, seg = 7'b1000000 during index 3.
REQ-030 SHALL test reset: assert rst at cycle 25 of a frame. Expected: the next edge gives an = 1111, seg = 1111111, dp = 1; after release the scan restarts at index 0.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the multiplexed clock display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/clock_display_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-BCD codes (10-15) render as a dash.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_driver.sv
// Four-digit multiplexed clock display with anti-ghost blanking and 1 Hz colon dp.
// Optional LEADING_ZERO_BLANK_EN suppresses a leading zero in the leftmost digit.
module clock_display_driver
  import clock_disp_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       mode_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIG_CYC  = CLK_HZ / REFRESH_HZ;
  localparam int HALF_CYC = CLK_HZ / 2;
  localparam int SLOT_W   = $clog2(DIG_CYC);
  localparam int HALF_W   = $clog2(HALF_CYC);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIG_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF_CYC - 1);

  logic [SLOT_W-1:0] r_slot_cnt;
  logic [HALF_W-1:0] r_half_cnt;
  digit_idx_t        r_idx;
  logic              r_phase;
  logic              r_first;
  logic [3:0][3:0]   r_snap;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic              w_slot_end;
  logic              w_half_end;
  logic              w_capture;
  logic [3:0][3:0]   w_frame;
  logic [3:0]        w_digit;
  logic [6:0]        w_seg_dec;
  logic              w_blank;
  logic              w_lz_off;
  logic              w_off;

  assign w_slot_end = (r_slot_cnt == SLOT_LAST);
  assign w_half_end = (r_half_cnt == HALF_LAST);
  // Capture on the first cycle out of reset and whenever the scan wraps to index 0.
  assign w_capture  = r_first | (w_slot_end && (r_idx == 2'd3));
  assign w_frame    = mode_sel ? {m2, m1, s2, s1} : {h2, h1, m2, m1};
  assign w_digit    = r_snap[r_idx];
  assign w_blank    = (r_slot_cnt < SLOT_BLANK);

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_off = (r_idx == 2'd3) && (r_snap[3] == 4'd0);
`else
  assign w_lz_off = 1'b0;
`endif

  assign w_off = w_blank | w_lz_off;

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_half_cnt <= '0;
      r_idx      <= 2'd0;
      r_phase    <= 1'b1;
      r_first    <= 1'b1;
      r_snap     <= '0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b1;
    end else begin
      r_first    <= 1'b0;
      r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
      r_half_cnt <= w_half_end ? '0 : r_half_cnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_half_end) begin
        r_phase <= ~r_phase;
      end
      if (w_capture) begin
        r_snap <= w_frame;
      end
      r_an  <= w_off ? AN_OFF : ~(4'b0001 << r_idx);
      r_seg <= w_off ? SEG_BLANK : w_seg_dec;
      r_dp  <= ~((r_idx == 2'd2) && !w_blank && r_phase);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver: stimulus queues expected outputs per edge,
// a negedge monitor pops and compares them.
module tb_clock_display_driver;

  localparam int CLK_HZ     = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int BLANK_CYC  = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  // Hand-coded digit patterns, packed {idx3, idx2, idx1, idx0}
  localparam logic [27:0] S_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] S_1237 = {7'h79, 7'h24, 7'h30, 7'h78};
  localparam logic [27:0] S_375D = {7'h30, 7'h78, 7'h12, 7'h3F};
  localparam logic [27:0] S_0237 = {7'h40, 7'h24, 7'h30, 7'h78};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       seg_care;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] h2, h1, m2, m1, s2, s1;
  logic       mode_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n = 0;

  always #5 clk = ~clk;

  clock_display_driver #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .h2       (h2),
    .h1       (h1),
    .m2       (m2),
    .m1       (m1),
    .s2       (s2),
    .s1       (s1),
    .mode_sel (mode_sel),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // Monitor: one pop per edge that the stimulus annotated
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (an !== e.an || dp !== e.dp || (e.seg_care && seg !== e.seg)) begin
        errors++;
        $display("FAIL %s t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 nm, $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic reset_edges(input string nm, input int k);
    exp_t e;
    e.an = 4'b1111; e.seg = 7'b1111111; e.seg_care = 1'b1; e.dp = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    $display("reset %s: %0d edges queued", nm, k);
  endtask

  // Output after edge n reflects slot n%10, index (n/10)%4, phase lit while (n/500) even
  task automatic run(input string nm, input int cycles, input logic [27:0] segs, input bit lz3);
    int   slot;
    int   idx;
    bit   off;
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      slot = n % 10;
      idx  = (n / 10) % 4;
      off  = (slot < BLANK_CYC) || (lz3 && idx == 3);
      e.an       = off ? 4'b1111 : ~(4'b0001 << idx);
      e.seg      = segs[idx*7 +: 7];
      e.seg_care = !off;
      e.dp       = (idx == 2 && slot >= BLANK_CYC && ((n / 500) % 2 == 0)) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      n++;
    end
    $display("run %s: %0d cycles queued, n=%0d", nm, cycles, n);
  endtask

  initial begin
    h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd5; s1 = 4'd6;
    mode_sel = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    reset_edges("reset_state", 2);
    rst = 0;
    n = 0;

    run("scan_f0_pre", 25, S_1234, 1'b0);
    m1 = 4'd7;
    run("scan_f0_hold", 15, S_1234, 1'b0);
    run("newframe_m1", 40, S_1237, 1'b0);
    run("dp_blink", 920, S_1237, 1'b0);

    mode_sel = 1'b1; s1 = 4'hC;
    run("mode_pending", 40, S_1237, 1'b0);
    run("mode1_dash", 40, S_375D, 1'b0);

    mode_sel = 1'b0; h2 = 4'd0;
    run("lz_pending", 40, S_375D, 1'b0);
    run("lead_zero", 40, S_0237, LZ);

    run("pre_reset", 25, S_0237, LZ);
    rst = 1'b1;
    h2 = 4'd1; m1 = 4'd4;
    reset_edges("mid_reset", 2);
    rst = 1'b0;
    n = 0;
    run("post_reset", 40, S_1234, 1'b0);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
